// File: rtl/rom_arbiter_pkg.sv
// Shared types and constants for the two-port ROM arbiter.
package rom_arbiter_pkg;

  // Arbiter states: free arbitration, or owned exclusively by one port.
  typedef enum logic [1:0] {
    StArb   = 2'd0,
    StLockA = 2'd1,
    StLockB = 2'd2
  } arb_state_e;

  // Round-robin pointer: names the port that wins a tie.
  typedef enum logic {
    SelA = 1'b0,
    SelB = 1'b1
  } port_sel_e;

  // Read data returned for out-of-window requests.
  localparam logic [7:0] ErrFill = 8'hFF;

endpackage

// File: rtl/rom_arbiter_if.sv
// Request/response bus for both arbiter ports plus the ROM strobe interface.
interface rom_arbiter_if;
  logic        a_req;
  logic        a_lock;
  logic [15:0] a_addr;
  logic        a_gnt;
  logic        a_rvalid;
  logic [7:0]  a_rdata;
  logic        a_err;

  logic        b_req;
  logic        b_lock;
  logic [15:0] b_addr;
  logic        b_gnt;
  logic        b_rvalid;
  logic [7:0]  b_rdata;
  logic        b_err;

  logic        rom_enable;
  logic        rom_read;
  logic [15:0] rom_addra;
  logic [7:0]  rom_douta;

  // Arbiter side.
  modport slave (
    input  a_req, a_lock, a_addr, b_req, b_lock, b_addr, rom_douta,
    output a_gnt, a_rvalid, a_rdata, a_err, b_gnt, b_rvalid, b_rdata, b_err,
    output rom_enable, rom_read, rom_addra
  );

  // Requester/ROM side.
  modport master (
    output a_req, a_lock, a_addr, b_req, b_lock, b_addr, rom_douta,
    input  a_gnt, a_rvalid, a_rdata, a_err, b_gnt, b_rvalid, b_rdata, b_err,
    input  rom_enable, rom_read, rom_addra
  );
endinterface

// File: rtl/rom_window_decode.sv
// Combinational ROM window check and word offset for one requesting port.
module rom_window_decode #(
  parameter int unsigned ROM_ADDR_BITS = 14,
  parameter logic [15:0] ROM_BASE      = 16'hC000
) (
  input  logic [15:0] i_addr,
  output logic        o_in_window,
  output logic [15:0] o_offset
);
  logic [15:0] w_offset;
  logic [16:0] w_size;

  // Offset wraps modulo 2**16; the lower-bound compare keeps wrapped addresses out.
  assign w_offset    = i_addr - ROM_BASE;
  assign w_size      = 17'(1) << ROM_ADDR_BITS;
  assign o_in_window = (i_addr >= ROM_BASE) && ({1'b0, w_offset} < w_size);
  assign o_offset    = w_offset;
endmodule

// File: rtl/rom_arbiter.sv
// Two-port round-robin arbiter with lock support in front of a shared synchronous ROM.
module rom_arbiter
  import rom_arbiter_pkg::*;
#(
  parameter int unsigned ROM_ADDR_BITS = 14,
  parameter logic [15:0] ROM_BASE      = 16'hC000
) (
  input  logic          clk,
  input  logic          reset,
  rom_arbiter_if.slave  bus
);
  logic        w_a_in, w_b_in;
  logic [15:0] w_a_off, w_b_off;
  arb_state_e  r_state, w_state_next;
  port_sel_e   r_ptr, w_ptr_next;
  logic        w_a_gnt, w_b_gnt, w_arb;
  logic        r_a_rvalid, r_a_err, r_b_rvalid, r_b_err;
  logic        w_a_valid, w_b_valid;
  logic [7:0]  r_a_hold, r_b_hold, w_a_rdata, w_b_rdata;

  rom_window_decode #(.ROM_ADDR_BITS(ROM_ADDR_BITS), .ROM_BASE(ROM_BASE)) u_dec_a (
    .i_addr      (bus.a_addr),
    .o_in_window (w_a_in),
    .o_offset    (w_a_off)
  );

  rom_window_decode #(.ROM_ADDR_BITS(ROM_ADDR_BITS), .ROM_BASE(ROM_BASE)) u_dec_b (
    .i_addr      (bus.b_addr),
    .o_in_window (w_b_in),
    .o_offset    (w_b_off)
  );

  // Grant selection, lock tracking and round-robin pointer update.
  always_comb begin
    w_a_gnt      = 1'b0;
    w_b_gnt      = 1'b0;
    w_arb        = 1'b0;
    w_state_next = r_state;
    w_ptr_next   = r_ptr;
    case (r_state)
      StLockA: begin
        if (bus.a_lock) w_a_gnt = bus.a_req;
        else            w_arb   = 1'b1;
      end
      StLockB: begin
        if (bus.b_lock) w_b_gnt = bus.b_req;
        else            w_arb   = 1'b1;
      end
      default: w_arb = 1'b1;
    endcase
    if (w_arb) begin
      // Releasing a lock arbitrates in the same cycle.
      w_state_next = StArb;
      if (bus.a_req && bus.b_req) begin
        w_a_gnt = (r_ptr == SelA);
        w_b_gnt = (r_ptr == SelB);
      end else begin
        w_a_gnt = bus.a_req;
        w_b_gnt = bus.b_req;
      end
    end
    if (w_a_gnt) begin
      w_ptr_next = SelB;
      if (bus.a_lock) w_state_next = StLockA;
    end
    if (w_b_gnt) begin
      w_ptr_next = SelA;
      if (bus.b_lock) w_state_next = StLockB;
    end
    if (reset) begin
      w_a_gnt      = 1'b0;
      w_b_gnt      = 1'b0;
      w_state_next = StArb;
      w_ptr_next   = SelA;
    end
  end

  // ROM strobes follow the granted port only when its address is in the window.
  always_comb begin
    bus.rom_enable = 1'b0;
    bus.rom_read   = 1'b0;
    bus.rom_addra  = 16'h0000;
    if (w_a_gnt && w_a_in) begin
      bus.rom_enable = 1'b1;
      bus.rom_read   = 1'b1;
      bus.rom_addra  = w_a_off;
    end else if (w_b_gnt && w_b_in) begin
      bus.rom_enable = 1'b1;
      bus.rom_read   = 1'b1;
      bus.rom_addra  = w_b_off;
    end
  end

  // Arbiter state and round-robin pointer.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= StArb;
      r_ptr   <= SelA;
    end else begin
      r_state <= w_state_next;
      r_ptr   <= w_ptr_next;
    end
  end

  // One-cycle response pipeline and per-port read data hold.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_a_rvalid <= 1'b0;
      r_a_err    <= 1'b0;
      r_b_rvalid <= 1'b0;
      r_b_err    <= 1'b0;
      r_a_hold   <= 8'h00;
      r_b_hold   <= 8'h00;
    end else begin
      r_a_rvalid <= w_a_gnt;
      r_a_err    <= w_a_gnt & ~w_a_in;
      r_b_rvalid <= w_b_gnt;
      r_b_err    <= w_b_gnt & ~w_b_in;
      if (w_a_valid) r_a_hold <= w_a_rdata;
      if (w_b_valid) r_b_hold <= w_b_rdata;
    end
  end

  // Reset in the response cycle cancels the pending response.
  assign w_a_valid = r_a_rvalid & ~reset;
  assign w_b_valid = r_b_rvalid & ~reset;
  // ROM data arrives one cycle after the read strobe, so rdata is muxed, not registered.
  assign w_a_rdata = w_a_valid ? (r_a_err ? ErrFill : bus.rom_douta) : r_a_hold;
  assign w_b_rdata = w_b_valid ? (r_b_err ? ErrFill : bus.rom_douta) : r_b_hold;

  assign bus.a_gnt    = w_a_gnt;
  assign bus.b_gnt    = w_b_gnt;
  assign bus.a_rvalid = w_a_valid;
  assign bus.b_rvalid = w_b_valid;
  assign bus.a_err    = r_a_err & ~reset;
  assign bus.b_err    = r_b_err & ~reset;
  assign bus.a_rdata  = w_a_rdata;
  assign bus.b_rdata  = w_b_rdata;
endmodule

// File: doc/rom_arbiter.md
ROM_ARBITER -- requirements
Module: rom_arbiter

Interface
REQ-001 Parameter ROM_ADDR_BITS, default 14, word-address width of the shared 8-bit synchronous ROM.
REQ-002 Parameter ROM_BASE, default 16'hC000, first 16-bit address mapped to ROM word 0.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 a_req / b_req  input  1  read request from port A (CPU) / port B (loader); held until granted.
REQ-006 a_lock / b_lock  input  1  sampled with grant; requests exclusive ownership.
REQ-007 a_addr / b_addr  input  16  requested byte address.
REQ-008 a_gnt / b_gnt  output  1  combinational; request accepted this cycle.
REQ-009 a_rvalid / b_rvalid  output  1  registered; read data valid this cycle.
REQ-010 a_rdata / b_rdata  output  8  read data, qualified by rvalid.
REQ-011 a_err / b_err  output  1  registered; accompanies rvalid when address was outside the window.
REQ-012 rom_enable, rom_read  output  1  ROM strobes; rom_addra  output  16; rom_douta  input  8.

Function
REQ-013 Window: addr in [ROM_BASE, ROM_BASE + 2**ROM_ADDR_BITS - 1]; out-of-window requests are granted but issue no ROM read.
REQ-014 At most one gnt per cycle; one request accepted per cycle (full throughput).
REQ-015 In-window grant drives rom_enable=1, rom_read=1, rom_addra = addr - ROM_BASE in the same cycle; otherwise all three are 0.
REQ-016 Latency: granted port sees rvalid exactly one cycle after gnt; rdata = rom_douta (in-window) or 8'hFF with err=1 (out-of-window).
REQ-017 Non-granted port's rvalid/err are 0; rdata of the non-valid port holds its last value.
REQ-018 FSM states ARB, LOCK_A, LOCK_B.
REQ-019 ARB: single requester wins; both requesting -> round-robin, port not granted most recently wins; pointer updates on every grant.
REQ-020 ARB -> LOCK_A when A granted with a_lock=1; ARB -> LOCK_B likewise for B.
REQ-021 LOCK_A: only A may be granted; b_req stalls (b_gnt=0) regardless of pointer.
REQ-022 LOCK_A -> ARB on first cycle a_lock=0 (with or without a_req); that cycle arbitrates as ARB. LOCK_B symmetric.
REQ-023 Locked owner with a_req=0 and a_lock=1: no grant, ROM idle, state unchanged.
REQ-024 Address wrap: ROM_BASE + offset computation is modulo 2**16; addresses below ROM_BASE are out-of-window, never aliased.
REQ-025 Grant is independent of rvalid: back-to-back grants to the same port produce back-to-back rvalids.

Reset
REQ-026 While reset=1: state ARB, pointer favours A, a_gnt=b_gnt=0, rom_enable=rom_read=0, rom_addra=0.
REQ-027 Registered outputs after reset: a_rvalid=b_rvalid=0, a_err=b_err=0, a_rdata=b_rdata=8'h00.
REQ-028 Reset asserted the cycle after a grant cancels that response: no rvalid is produced.
REQ-029 Reset clears any lock; first post-reset cycle arbitrates from ARB.

Structure
REQ-030 Shared package holds FSM state encoding (ARB, LOCK_A, LOCK_B), port-select encoding, and the 8'hFF error-fill constant.
REQ-031 One sub-module, rom_window_decode: combinational in-window check and offset subtraction, instantiated once per port.
REQ-032 Arbiter is parameter-agnostic beyond ROM_ADDR_BITS/ROM_BASE; implementation 120-400 lines.

Verification
REQ-033 Single A read at 16'hC000, ROM[0]=8'hA9 -> a_gnt same cycle, rom_addra=0, next cycle a_rvalid=1, a_rdata=8'hA9.
REQ-034 A and B request continuously from reset -> grants alternate A,B,A,B; each rvalid one cycle after its gnt.
REQ-035 B granted with b_lock=1, A requesting for 5 cycles, b_lock drops cycle 4 -> A stalled cycles 1-3, A granted in cycle 4.
REQ-036 A reads 16'h8000 -> a_gnt=1, rom_enable=0, next cycle a_rvalid=1, a_err=1, a_rdata=8'hFF.
REQ-037 Grant to A then reset next cycle -> a_rvalid stays 0, outputs at reset values, state ARB with A priority.
REQ-038 A reads 16'hFFFF (last word) -> rom_addra=16'h3FFF, a_err=0.
